// File: rtl/pipe_store_buffer_if.sv
// Bus bundle between the MEM stage, the store buffer and the single-port data memory.
// master = pipeline/memory side, slave = the store buffer itself.
interface pipe_store_buffer_if;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_datain;
   logic        cpu_we;
   logic        cpu_re;
   logic [31:0] cpu_dataout;
   logic        stall;
   logic        empty;
   logic [31:0] mem_addr;
   logic [31:0] mem_datain;
   logic        mem_we;
   logic [31:0] mem_dataout;
   logic        mem_ready;

   modport master (
      output cpu_addr, cpu_datain, cpu_we, cpu_re, mem_dataout, mem_ready,
      input  cpu_dataout, stall, empty, mem_addr, mem_datain, mem_we
   );

   modport slave (
      input  cpu_addr, cpu_datain, cpu_we, cpu_re, mem_dataout, mem_ready,
      output cpu_dataout, stall, empty, mem_addr, mem_datain, mem_we
   );
endinterface

// File: rtl/pipe_store_buffer.sv
// Word store buffer: FIFO of pending stores drained to the data memory when no load
// needs the port; loads are forwarded from the youngest matching queued store.

// Per-slot forwarding match: slot is live if it lies within count entries of head.
module psb_slot_match #(
   parameter int SLOT  = 0,
   parameter int PTR_W = 2
) (
   input  logic [PTR_W-1:0] head,
   input  logic [PTR_W:0]   count,
   input  logic [29:0]      ent_addr,
   input  logic [29:0]      key,
   output logic             hit
);
   logic [PTR_W-1:0] offset;

   assign offset = PTR_W'(SLOT) - head;
   assign hit    = ({1'b0, offset} < count) && (ent_addr == key);
endmodule

// DEPTH must be a power of two and at least 2 so the pointers wrap for free.
module pipe_store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              clrn,
   pipe_store_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
   } entry_t;

   entry_t           q [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic             full, empty, push, pop;
   logic [DEPTH-1:0] hit;
   logic             fwd_hit;
   logic [31:0]      fwd_data;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign bus.empty = empty;
   assign bus.stall = bus.cpu_we & full & ~pop;
   assign push      = bus.cpu_we & ~bus.stall;

   // Loads own the port; drains only use it when it would otherwise sit idle.
   always_comb begin
      pop            = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = bus.cpu_addr;
      bus.mem_datain = '0;
      if (!bus.cpu_re && !empty && bus.mem_ready) begin
         pop            = 1'b1;
         bus.mem_we     = 1'b1;
         bus.mem_addr   = {q[head].addr, 2'b00};
         bus.mem_datain = q[head].data;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Entry payload needs no reset: only slots inside [head, head+count) are ever read.
   always_ff @(posedge clk) begin
      if (push) q[tail] <= '{addr: bus.cpu_addr[31:2], data: bus.cpu_datain};
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_match
      psb_slot_match #(.SLOT(i), .PTR_W(PTR_W)) u_match (
         .head     (head),
         .count    (count),
         .ent_addr (q[i].addr),
         .key      (bus.cpu_addr[31:2]),
         .hit      (hit[i])
      );
   end

   // Walk oldest to youngest so the last hit seen is the newest store to that word.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         automatic logic [PTR_W-1:0] slot = head + PTR_W'(k);
         if (hit[slot]) begin
            fwd_hit  = 1'b1;
            fwd_data = q[slot].data;
         end
      end
   end

   assign bus.cpu_dataout = fwd_hit ? fwd_data : bus.mem_dataout;
endmodule

// File: tb/tb_pipe_store_buffer.sv
// Bench for pipe_store_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_store_buffer;
   localparam int DEPTH = 4;

   typedef struct {
      logic [29:0] a;
      logic [31:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic clrn;
   int   errors = 0;
   int   checks = 0;

   pipe_store_buffer_if bus ();

   pipe_store_buffer #(.DEPTH(DEPTH)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Data memory: async read, write on clk edge; unwritten words hold a known pattern.
   logic [31:0]  tbmem [256];
   bit   [255:0] tb_wr;
   logic [63:0]  act_log [$];

   function automatic logic [31:0] pat(input int i);
      return 32'hA000_0000 | 32'(i);
   endfunction

   assign bus.mem_dataout = tb_wr[bus.mem_addr[9:2]] ? tbmem[bus.mem_addr[9:2]] : pat(int'(bus.mem_addr[9:2]));

   always @(posedge clk) begin
      if (bus.mem_we) begin
         tbmem[bus.mem_datain === 'x ? 0 : bus.mem_addr[9:2]] <= bus.mem_datain;
         tb_wr[bus.mem_addr[9:2]] <= 1'b1;
         act_log.push_back({bus.mem_addr, bus.mem_datain});
      end
   end

   // Reference model: a queue of pending stores and the memory image they produce.
   ent_t        mq [$];
   logic [31:0] exmem [256];
   bit   [255:0] ex_wr;
   logic [63:0] exp_log [$];

   function automatic logic [31:0] ex_read(input logic [31:0] addr);
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].a == addr[31:2]) return mq[i].d;
      return ex_wr[addr[9:2]] ? exmem[addr[9:2]] : pat(int'(addr[9:2]));
   endfunction

   function automatic bit ex_pop();
      return !bus.cpu_re && mq.size() > 0 && bus.mem_ready;
   endfunction

   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         mq.delete();
      end else begin
         automatic bit p = ex_pop();
         automatic bit s = bus.cpu_we && mq.size() == DEPTH && !p;
         if (p) begin
            exmem[mq[0].a[7:0]] = mq[0].d;
            ex_wr[mq[0].a[7:0]] = 1'b1;
            exp_log.push_back({mq[0].a, 2'b00, mq[0].d});
            void'(mq.pop_front());
         end
         if (bus.cpu_we && !s) mq.push_back('{a: bus.cpu_addr[31:2], d: bus.cpu_datain});
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      automatic bit p = ex_pop();
      automatic bit s = bus.cpu_we && mq.size() == DEPTH && !p;
      chk("m_stall",  32'(bus.stall),  32'(s));
      chk("m_empty",  32'(bus.empty),  32'(mq.size() == 0));
      chk("m_mem_we", 32'(bus.mem_we), 32'(p));
      chk("m_mem_addr", bus.mem_addr, p ? {mq[0].a, 2'b00} : bus.cpu_addr);
      if (!bus.cpu_re) chk("m_mem_datain", bus.mem_datain, p ? mq[0].d : 32'h0);
      if (bus.cpu_re)  chk("m_dataout", bus.cpu_dataout, ex_read(bus.cpu_addr));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
      bus.cpu_we     = we;
      bus.cpu_re     = re;
      bus.cpu_addr   = a;
      bus.cpu_datain = d;
   endtask

   initial begin
      clrn          = 1'b0;
      bus.mem_ready = 1'b1;
      drive(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);

      // Reset holds everything empty even with a store request asserted.
      @(negedge clk);
      @(negedge clk);
      chk("rst_empty",  32'(bus.empty),  32'd1);
      chk("rst_stall",  32'(bus.stall),  32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      tick();
      clrn = 1'b1;
      drive(1'b1, 1'b0, 32'h10, 32'h4080_0000);
      @(negedge clk);
      chk("st_not_same_cycle", 32'(bus.mem_we), 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("drain_we",   32'(bus.mem_we),  32'd1);
      chk("drain_addr", bus.mem_addr,     32'h10);
      chk("drain_data", bus.mem_datain,   32'h4080_0000);
      tick();
      @(negedge clk);
      chk("drain_empty", 32'(bus.empty), 32'd1);

      // Forwarding picks the youngest store; other words come from memory.
      tick();
      bus.mem_ready = 1'b0;
      drive(1'b1, 1'b0, 32'h50, 32'h1111_1111); tick();
      drive(1'b1, 1'b0, 32'h50, 32'h2222_2222); tick();
      drive(1'b0, 1'b1, 32'h50, 32'h0);
      @(negedge clk);
      chk("fwd_young", bus.cpu_dataout, 32'h2222_2222);
      tick();
      drive(1'b0, 1'b1, 32'h54, 32'h0);
      @(negedge clk);
      chk("fwd_miss", bus.cpu_dataout, 32'hA000_0015);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      bus.mem_ready = 1'b1;
      tick(); tick();
      drive(1'b0, 1'b1, 32'h50, 32'h0);
      @(negedge clk);
      chk("mem_last_wins", bus.cpu_dataout, 32'h2222_2222);
      tick();

      // Full: fifth store stalls until a drain frees a slot in the same cycle.
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 32'h60 + 32'(4 * i), 32'h6000_0000 + 32'(i));
         tick();
      end
      drive(1'b1, 1'b0, 32'h70, 32'h7777_7777);
      @(negedge clk);
      chk("full_stall", 32'(bus.stall), 32'd1);
      tick();
      @(negedge clk);
      chk("full_stall_hold", 32'(bus.stall), 32'd1);
      tick();
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("full_unstall", 32'(bus.stall),  32'd0);
      chk("full_pop_addr", bus.mem_addr,   32'h60);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      for (int n = 0; n < 20 && !bus.empty; n++) tick();
      chk("full_drained", 32'(bus.empty), 32'd1);

      // Loads take the port and starve the drain.
      bus.mem_ready = 1'b0;
      drive(1'b1, 1'b0, 32'h80, 32'h8000_0000); tick();
      drive(1'b1, 1'b0, 32'h84, 32'h8400_0000); tick();
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 32'h84, 32'h0);
         @(negedge clk);
         chk("ld_prio_we",  32'(bus.mem_we),  32'd0);
         chk("ld_prio_fwd", bus.cpu_dataout,  32'h8400_0000);
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("ld_prio_d0", bus.mem_addr, 32'h80);
      tick();
      @(negedge clk);
      chk("ld_prio_d1", bus.mem_addr, 32'h84);
      tick();
      @(negedge clk);
      chk("ld_prio_empty", 32'(bus.empty), 32'd1);

      // Wrap-around with drains interleaved.
      for (int i = 0; i < 10; i++) begin
         bus.mem_ready = (i % 3) != 0;
         drive(1'b1, 1'b0, 32'(4 * i), 32'hC000_0000 + 32'(i));
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      bus.mem_ready = 1'b1;
      for (int n = 0; n < 20 && !bus.empty; n++) tick();
      chk("wrap_drained", 32'(bus.empty), 32'd1);

      // Reset between edges discards pending stores.
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'h90 + 32'(4 * i), 32'h9000_0000 + 32'(i));
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      #1 clrn = 1'b0;
      #1 chk("midrst_empty", 32'(bus.empty), 32'd1);
      #1 clrn = 1'b1;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("midrst_no_we", 32'(bus.mem_we), 32'd0);
         tick();
      end

      // Write order and final memory image.
      chk("log_len", 32'(act_log.size()), 32'(exp_log.size()));
      for (int i = 0; i < exp_log.size() && i < act_log.size(); i++) begin
         chk("log_addr", act_log[i][63:32], exp_log[i][63:32]);
         chk("log_data", act_log[i][31:0],  exp_log[i][31:0]);
      end
      chk("log_first", exp_log.size() > 0 ? exp_log[0][63:32] : 32'hFFFF_FFFF, 32'h10);
      chk("mem_wrap_last", tb_wr[9] ? tbmem[9] : 32'h0, 32'hC000_0009);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end
endmodule
